lsu_sram_master: RTL

- Load/store unit on the core side of the data SRAM port; it is the initiator that drives the single-port, byte-maskable data SRAM.
- Accepts one load/store request at a time from the execute stage and drives SRAM address, data and the active-low strobes.
- Aligns and sign-extends read data and returns a one-cycle response.
- Misaligned accesses are split into two SRAM word accesses, or rejected with an error, selected by parameter.

---
 rtl/lsu_sram_master.sv | 117 +++++++++++
 1 files changed

// File: rtl/lsu_sram_master.sv
// lsu_sram_master: load/store unit driving a single-port byte-maskable data SRAM
// Misaligned accesses are split into two word accesses or rejected, per SPLIT_MISALIGNED.
module lsu_sram_master #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);
  localparam logic [1:0] IDLE = 2'd0, ACC_A = 2'd1, ACC_B = 2'd2, FIN = 2'd3;
  logic [1:0]  st, sz, o;
  logic        we, uns, split, req_split;
  logic [29:0] wrd;
  logic [7:0]  lanes, req_lanes;
  logic [3:0]  req_mask;
  logic [4:0]  req_sh, sh;
  logic [31:0] wa, amask, merged, rot, ext, req_din;
  always_comb begin
    req_mask  = req_size == 2'd0 ? 4'h1 : req_size == 2'd1 ? 4'h3 : 4'hF;
    req_lanes = {4'h0, req_mask} << req_addr[1:0];
    req_split = |req_lanes[7:4];
    req_sh    = {req_addr[1:0], 3'b000};
    req_din   = (req_wdata << req_sh) | (req_wdata >> (32 - req_sh));
    split     = |lanes[7:4];
    sh        = {o, 3'b000};
    // lanes of word A come from the captured first read, the rest from the second
    amask     = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    merged    = split ? (wa & amask) | (sram_dout & ~amask) : sram_dout;
    rot       = (merged >> sh) | (merged << (32 - sh));
    ext       = sz == 2'd0 ? {{24{~uns & rot[7]}}, rot[7:0]} :
                sz == 2'd1 ? {{16{~uns & rot[15]}}, rot[15:0]} : rot;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_ben  <= 4'hF;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (st)
        IDLE: if (req_valid) begin
          if (req_split && !SPLIT_MISALIGNED) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            st        <= ACC_A;
            req_ready <= 1'b0;
            we        <= req_we;
            sz        <= req_size;
            uns       <= req_unsigned;
            o         <= req_addr[1:0];
            wrd       <= req_addr[31:2];
            lanes     <= req_lanes;
            sram_cen  <= 1'b0;
            sram_wen  <= ~req_we;
            sram_ben  <= ~req_lanes[3:0];
            sram_addr <= {req_addr[31:2], 2'b00};
            sram_din  <= req_din;
          end
        end
        ACC_A: if (split) begin
          st        <= ACC_B;
          sram_ben  <= ~lanes[7:4];
          sram_addr <= {wrd + 30'd1, 2'b00};
        end else begin
          st        <= we ? IDLE : FIN;
          req_ready <= we;
          rsp_valid <= we;
          rsp_rdata <= we ? '0 : rsp_rdata;
          sram_cen  <= 1'b1;
          sram_wen  <= 1'b1;
          sram_ben  <= 4'hF;
        end
        ACC_B: begin
          wa        <= sram_dout;
          st        <= we ? IDLE : FIN;
          req_ready <= we;
          rsp_valid <= we;
          rsp_rdata <= we ? '0 : rsp_rdata;
          sram_cen  <= 1'b1;
          sram_wen  <= 1'b1;
          sram_ben  <= 4'hF;
        end
        FIN: begin
          st        <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= ext;
        end
      endcase
    end
  end
endmodule
